// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared types and constants for the dds_nco oscillator
// Contents: dds_state_e (IDLE/LOAD/RUN), LFSR_TAPS/LFSR_SEED for the optional
// phase dither (DDS_DITHER_EN), bytes_per_word() for LUT word assembly.
package dds_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } dds_state_e;

   // Fibonacci taps 16,14,13,11 -> bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   function automatic int bytes_per_word(input int width);
      return (width + 7) / 8;
   endfunction

endpackage

// File: rtl/dds_lut.sv
// rtl/dds_lut.sv - waveform table: simple dual-port block RAM
// Ports: clk; reset (async, active-low, clears the read register only);
//        wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request;
//        rd_data registered read data (holds while rd_en=0).
// The array itself is never reset.
module dds_lut #(
   parameter int LUT_AW = 12,
   parameter int LUT_DW = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [LUT_AW-1:0] wr_addr,
   input  logic [LUT_DW-1:0] wr_data,
   input  logic              rd_en,
   input  logic [LUT_AW-1:0] rd_addr,
   output logic [LUT_DW-1:0] rd_data
);

   (* ram_style = "block" *) logic [LUT_DW-1:0] mem [2**LUT_AW];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/dds_nco.sv
// rtl/dds_nco.sv - phase-accumulator DDS with FM/PM and byte-loaded waveform LUT
// Ports: clk; reset (async, active-low); cfg/cfg_ce LUT load bytes (little-endian
//        per entry); step phase increment (0 = stop); sync clears the accumulator;
//        fm_data added to step each RUN cycle; pm_data top LUT_AW bits offset the
//        LUT address; out sign-extended sample, out_valid, load_done (sticky).
// Optional: define DDS_DITHER_EN to add 16-bit LFSR phase dither to the address.
module dds_nco
   import dds_pkg::*;
#(
   parameter int PHASE_W = 32,
   parameter int LUT_AW  = 12,
   parameter int LUT_DW  = 8,
   parameter int OUT_W   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         cfg,
   input  logic               cfg_ce,
   input  logic [PHASE_W-1:0] step,
   input  logic               sync,
   input  logic [PHASE_W-1:0] fm_data,
   input  logic [PHASE_W-1:0] pm_data,
   output logic [OUT_W-1:0]   out,
   output logic               out_valid,
   output logic               load_done
);

   localparam int BPW    = bytes_per_word(LUT_DW);
   localparam int PTR_W  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int FRAC_W = PHASE_W - LUT_AW;
   localparam logic [LUT_AW-1:0]  ADDR_LAST = '1;
   localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(BPW - 1);
   // Keeps only the pm_data bits that land on the LUT address.
   localparam logic [PHASE_W-1:0] PM_MASK = ~((PHASE_W'(1) << FRAC_W) - PHASE_W'(1));

   dds_state_e         state;
   logic [PHASE_W-1:0] accum;
   logic [PTR_W-1:0]   ptr, cur_ptr;
   logic [LUT_AW-1:0]  wr_addr, cur_addr, rd_addr, addr_next;
   logic [BPW*8-1:0]   word_buf, word_next;
   logic [1:0]         vpipe;
   logic [LUT_DW-1:0]  rd_data;
   logic [PHASE_W-1:0] dither, phase_sum;
   logic               load_entry, wr_en;

`ifdef DDS_DITHER_EN
   localparam int DITH_W = (FRAC_W < 16) ? FRAC_W : 16;
   localparam logic [15:0] DITH_MASK = 16'((32'd1 << DITH_W) - 32'd1);
   logic [15:0] lfsr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)            lfsr <= LFSR_SEED;
      else if (state == RUN) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
   end

   assign dither = PHASE_W'(lfsr & DITH_MASK);
`else
   assign dither = '0;
`endif

   // Dither only perturbs the address; the stored accumulator stays exact.
   assign phase_sum = accum + dither + (pm_data & PM_MASK);
   assign addr_next = LUT_AW'(phase_sum >> FRAC_W);

   // The byte that moves us into LOAD is already the first byte of entry 0.
   always_comb begin
      load_entry = cfg_ce && (state != LOAD);
      cur_ptr    = load_entry ? '0 : ptr;
      cur_addr   = load_entry ? '0 : wr_addr;
      word_next  = word_buf;
      word_next[int'(cur_ptr)*8 +: 8] = cfg;
      wr_en      = cfg_ce && (cur_ptr == PTR_LAST);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         accum     <= '0;
         ptr       <= '0;
         wr_addr   <= '0;
         word_buf  <= '0;
         load_done <= 1'b0;
         vpipe     <= '0;
         rd_addr   <= '0;
      end else begin
         rd_addr <= addr_next;
         vpipe   <= {vpipe[0], state == RUN};

         if (sync)              accum <= '0;
         else if (state == RUN) accum <= accum + step + fm_data;

         if (cfg_ce) begin
            state     <= LOAD;
            word_buf  <= word_next;
            ptr       <= wr_en ? '0 : cur_ptr + 1'b1;
            wr_addr   <= wr_en ? cur_addr + 1'b1 : cur_addr;
            load_done <= (load_done && !load_entry) || (wr_en && (cur_addr == ADDR_LAST));
         end else begin
            unique case (state)
               IDLE: if (step != '0) state <= RUN;
               LOAD: if (step != '0) begin
                  state   <= RUN;
                  ptr     <= '0;
                  wr_addr <= '0;
               end
               RUN:  if (step == '0) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   dds_lut #(
      .LUT_AW (LUT_AW),
      .LUT_DW (LUT_DW)
   ) u_lut (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (cur_addr),
      .wr_data (LUT_DW'(word_next)),
      .rd_en   (vpipe[0]),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign out       = OUT_W'($signed(rd_data));
   assign out_valid = vpipe[1];

endmodule

// File: tb/tb_dds_nco.sv
// tb/tb_dds_nco.sv - self-checking bench for dds_nco against a behavioural model
module tb_dds_nco;

   localparam int PW = 32;
   localparam int AW = 6;
   localparam int DW = 12;
   localparam int OW = 32;
   localparam int DEPTH = 64;
   localparam int FRAC = PW - AW;
   localparam int S_IDLE = 0;
   localparam int S_LOAD = 1;
   localparam int S_RUN  = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    cfg = '0;
   logic          cfg_ce = 1'b0;
   logic [PW-1:0] step = '0;
   logic          sync = 1'b0;
   logic [PW-1:0] fm_data = '0;
   logic [PW-1:0] pm_data = '0;
   logic [OW-1:0] out;
   logic          out_valid;
   logic          load_done;

   dds_nco #(
      .PHASE_W (PW),
      .LUT_AW  (AW),
      .LUT_DW  (DW),
      .OUT_W   (OW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cfg       (cfg),
      .cfg_ce    (cfg_ce),
      .step      (step),
      .sync      (sync),
      .fm_data   (fm_data),
      .pm_data   (pm_data),
      .out       (out),
      .out_valid (out_valid),
      .load_done (load_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model state
   int          ms;
   logic [31:0] acc;
   int          waddr, nbytes, byte0;
   bit          done;
   int          lut [DEPTH];
   bit          prev_v;
   int          prev_a;
   logic [31:0] exp_out;
   bit          exp_v;

   function automatic logic [31:0] sext(input int s);
      return (s >= 2048) ? 32'(s - 4096) : 32'(s);
   endfunction

   task automatic model_reset();
      ms = S_IDLE; acc = '0; waddr = 0; nbytes = 0; byte0 = 0; done = 0;
      prev_v = 0; prev_a = 0; exp_out = '0; exp_v = 0;
   endtask

   // One clock edge of the model, using the inputs the DUT just sampled.
   task automatic model_edge();
      exp_v = prev_v;
      if (prev_v) exp_out = sext(lut[prev_a]);
      prev_v = (ms == S_RUN);
      prev_a = int'(((acc >> FRAC) + (pm_data >> FRAC)) % DEPTH);

      if (sync)             acc = '0;
      else if (ms == S_RUN) acc = acc + step + fm_data;

      if (cfg_ce) begin
         if (ms != S_LOAD) begin nbytes = 0; waddr = 0; done = 0; end
         if (nbytes == 0) begin
            byte0 = int'(cfg); nbytes = 1;
         end else begin
            lut[waddr] = (byte0 + 256 * int'(cfg)) % 4096;
            if (waddr == DEPTH - 1) done = 1;
            waddr = (waddr + 1) % DEPTH;
            nbytes = 0;
         end
         ms = S_LOAD;
      end else if (ms == S_IDLE && step != 0) begin
         ms = S_RUN;
      end else if (ms == S_LOAD && step != 0) begin
         ms = S_RUN; nbytes = 0; waddr = 0;
      end else if (ms == S_RUN && step == 0) begin
         ms = S_IDLE;
      end
   endtask

   // Called at a negedge: drive, clock once, compare at the following negedge.
   task automatic cycle(input logic ce, input logic [7:0] b, input logic [31:0] st,
                        input logic sy, input logic [31:0] fm, input logic [31:0] pm);
      cfg_ce = ce; cfg = b; step = st; sync = sy; fm_data = fm; pm_data = pm;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("out", out, exp_out);
      check("out_valid", 32'(out_valid), 32'(exp_v));
      check("load_done", 32'(load_done), 32'(done));
   endtask

   task automatic load_table();
      for (int i = 0; i < 2 * DEPTH; i++) cycle(1'b1, 8'($urandom), '0, 1'b0, '0, '0);
   endtask

   task automatic random_run(input int n);
      for (int i = 0; i < n; i++)
         cycle($urandom_range(15) == 0, 8'($urandom),
               ($urandom_range(7) == 0) ? 32'd0 : 32'($urandom),
               $urandom_range(31) == 0, 32'($urandom), 32'($urandom));
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b0;
      #1;
      model_reset();
      check("rst_out", out, '0);
      check("rst_out_valid", 32'(out_valid), '0);
      check("rst_load_done", 32'(load_done), '0);
      @(negedge clk);
      cfg_ce = 1'b0; step = '0; sync = 1'b0; fm_data = '0; pm_data = '0;
      reset = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) lut[i] = 0;
      model_reset();
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      check("init_out", out, '0);
      check("init_out_valid", 32'(out_valid), '0);
      check("init_load_done", 32'(load_done), '0);
      reset = 1'b1;

      load_table();
      check("load_done_full", 32'(load_done), 32'd1);

      for (int i = 0; i < 70; i++) cycle(1'b0, '0, 32'h0400_0000, 1'b0, '0, '0);
      for (int i = 0; i < 20; i++) cycle(1'b0, '0, 32'hFC00_0000, 1'b0, '0, '0);
      for (int i = 0; i < 20; i++) cycle(1'b0, '0, 32'h0400_0000, 1'b0, '0, 32'h8000_0000);
      for (int i = 0; i < 10; i++) cycle(1'b0, '0, 32'h0400_0000, 1'b0, 32'hFC00_0000, '0);
      for (int i = 0; i < 5; i++)  cycle(1'b0, '0, '0, 1'b0, '0, '0);
      for (int i = 0; i < 12; i++) cycle(1'b0, '0, 32'h0100_0000, i == 6, '0, '0);

      // Load request in the middle of RUN, then sit in LOAD with step=0.
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 32'h0400_0000, 1'b0, '0, '0);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0);
      check("load_done_cleared", 32'(load_done), '0);
      check("drained_valid", 32'(out_valid), '0);

      load_table();
      random_run(600);
      for (int i = 0; i < 5; i++) cycle(1'b0, '0, 32'h0400_0000, 1'b0, '0, '0);
      pulse_reset();
      for (int i = 0; i < 20; i++) cycle(1'b0, '0, 32'h0400_0000, 1'b0, '0, '0);
      random_run(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
